// File: rtl/instr_fetch_buffer.sv
// In-order fetch buffer between the fetch unit and decode.
// Holds {pc, instr, fault} beats; faulted beats carry a NOP instruction word.
module instr_fetch_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_fetch_valid,
  output logic                     o_fetch_ready,
  input  logic [XLEN-1:0]          i_fetch_pc,
  input  logic [31:0]              i_fetch_instr,
  input  logic                     i_fetch_fault,
  output logic                     o_decode_valid,
  input  logic                     i_decode_ready,
  output logic [XLEN-1:0]          o_decode_pc,
  output logic [31:0]              o_decode_instr,
  output logic                     o_decode_fault,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int          PW  = $clog2(DEPTH);
  localparam int          CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  if (DEPTH != 2 && DEPTH != 4) begin : g_depth_check
    $error("instr_fetch_buffer: DEPTH must be 2 or 4");
  end

  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [31:0]     instr_mem_q [DEPTH];
  logic [DEPTH-1:0] fault_mem_q;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign o_fetch_ready  = (count_q != CW'(DEPTH));
  assign o_decode_valid = (count_q != '0);
  assign o_count        = count_q;

  always_comb begin
    push     = i_fetch_valid && o_fetch_ready && !i_flush;
    pop      = o_decode_valid && i_decode_ready && !i_flush;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is intentionally left unreset; validity comes from count_q.
  always_ff @(posedge i_clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= i_fetch_pc;
      instr_mem_q[wr_ptr_q] <= i_fetch_fault ? NOP : i_fetch_instr;
      fault_mem_q[wr_ptr_q] <= i_fetch_fault;
    end
  end

  always_comb begin
    o_decode_pc    = '0;
    o_decode_instr = NOP;
    o_decode_fault = 1'b0;
    if (o_decode_valid) begin
      o_decode_pc    = pc_mem_q[rd_ptr_q];
      o_decode_instr = instr_mem_q[rd_ptr_q];
      o_decode_fault = fault_mem_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed scenarios plus a random push/pop/flush stream checked against a queue model.
module tb_instr_fetch_buffer;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_flush;
  logic              i_fetch_valid;
  logic              o_fetch_ready;
  logic [XLEN-1:0]   i_fetch_pc;
  logic [31:0]       i_fetch_instr;
  logic              i_fetch_fault;
  logic              o_decode_valid;
  logic              i_decode_ready;
  logic [XLEN-1:0]   o_decode_pc;
  logic [31:0]       o_decode_instr;
  logic              o_decode_fault;
  logic [$clog2(DEPTH):0] o_count;

  instr_fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_flush        (i_flush),
    .i_fetch_valid  (i_fetch_valid),
    .o_fetch_ready  (o_fetch_ready),
    .i_fetch_pc     (i_fetch_pc),
    .i_fetch_instr  (i_fetch_instr),
    .i_fetch_fault  (i_fetch_fault),
    .o_decode_valid (o_decode_valid),
    .i_decode_ready (i_decode_ready),
    .o_decode_pc    (o_decode_pc),
    .o_decode_instr (o_decode_instr),
    .o_decode_fault (o_decode_fault),
    .o_count        (o_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            fault;
  } entry_t;

  entry_t model_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [63:0] e_pc, e_instr, e_fault;
    e_pc = 0; e_instr = 64'(NOP); e_fault = 0;
    if (model_q.size() != 0) begin
      e_pc    = 64'(model_q[0].pc);
      e_instr = 64'(model_q[0].instr);
      e_fault = 64'(model_q[0].fault);
    end
    chk({tag, ".count"}, 64'(o_count), 64'(model_q.size()));
    chk({tag, ".valid"}, 64'(o_decode_valid), 64'(model_q.size() != 0));
    chk({tag, ".ready"}, 64'(o_fetch_ready), 64'(model_q.size() != DEPTH));
    chk({tag, ".pc"}, 64'(o_decode_pc), e_pc);
    chk({tag, ".instr"}, 64'(o_decode_instr), e_instr);
    chk({tag, ".fault"}, 64'(o_decode_fault), e_fault);
  endtask

  task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic [31:0] ins,
                       input logic flt, input logic rdy, input logic fl);
    i_fetch_valid  = v;
    i_fetch_pc     = pc;
    i_fetch_instr  = ins;
    i_fetch_fault  = flt;
    i_decode_ready = rdy;
    i_flush        = fl;
  endtask

  // Advance one clock edge, apply the FIFO rules to the model, then check after the edge.
  task automatic step(input string tag);
    bit     do_push, do_pop;
    entry_t e;
    @(posedge i_clk);
    do_push = i_fetch_valid && (model_q.size() < DEPTH) && !i_flush;
    do_pop  = i_decode_ready && (model_q.size() > 0) && !i_flush;
    if (i_flush) model_q.delete();
    if (do_pop) void'(model_q.pop_front());
    if (do_push) begin
      e.pc    = i_fetch_pc;
      e.instr = i_fetch_fault ? NOP : i_fetch_instr;
      e.fault = i_fetch_fault;
      model_q.push_back(e);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    i_rst_n = 1'b0;
    drive(0, '0, '0, 0, 0, 0);
    #2;
    check_all("reset");
    #10 i_rst_n = 1'b1;

    // First edge after deassertion accepts a push.
    drive(1, 32'h100, 32'h0050_0093, 0, 0, 0);
    step("push1");
    drive(1, 32'h104, 32'h0000_0113, 0, 0, 0);
    step("full");
    // Full: beat 0x108 offered with a pop is refused this cycle.
    drive(1, 32'h108, 32'h0000_0193, 0, 1, 0);
    step("pop_when_full");
    // Simultaneous push and pop at count=1.
    drive(1, 32'h108, 32'h0000_0193, 0, 1, 0);
    step("push_pop");
    drive(1, 32'h10c, 32'h0000_0213, 0, 0, 0);
    step("refill");
    drive(1, 32'h200, 32'h0000_0293, 0, 1, 1);
    step("flush");
    drive(0, '0, '0, 0, 1, 0);
    step("after_flush");
    drive(1, 32'h300, 32'hFFFF_FFFF, 1, 0, 0);
    step("fault");
    drive(1, 32'h304, 32'h0000_0313, 0, 0, 0);
    step("fault_hold");
    drive(0, '0, '0, 0, 0, 0);
    step("stable");

    // Asynchronous reset between edges at count=2.
    #3 i_rst_n = 1'b0;
    #1;
    model_q.delete();
    check_all("async_reset");
    #2 i_rst_n = 1'b1;

    drive(1, 32'h400, 32'h0000_0413, 0, 0, 0);
    step("post_reset_push");
    drive(0, '0, '0, 0, 1, 0);
    step("post_reset_pop");

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0),
            XLEN'($urandom() & 32'hFFFF_FFFC),
            $urandom(),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 19) == 0));
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
